mul_seq_16: RTL and testbench
=============================

Name: mul_seq_16

Overview:
- Multi-cycle unsigned 16x16->32 shift-and-add multiplier for the Execute stage.
- Sequences one CLA_16bit instance (A, B, sub, Sum, Error) through 16 add/shift iterations instead of adding a dedicated array multiplier.
- Sits beside the ALU.
- Exposes a start/busy/done handshake so the stall logic can freeze the pipeline while a multiply is in flight.

Parameters:
- WIDTH, 16, operand width. Must equal the CLA_16bit width; any other value is a synthesis-time error.
- ITERS, WIDTH, number of add/shift iterations.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply. Sampled only in IDLE.
- abort  in  1  cancel in-flight multiply (pipeline flush).
- op_a  in  16  multiplier, unsigned.
- op_b  in  16  multiplicand, unsigned.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when prod is updated.
- prod  out  32  last completed product. Held until the next completion.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - state=IDLE, busy=0, done=0, prod=0.
  - hi=0, lo=0, mcand=0, cnt=0.
- State machine:
  - States: IDLE, RUN, DONE.
  - IDLE: if start and not abort, then lo<=op_a, mcand<=op_b, hi<=0, cnt<=0, go to RUN. Otherwise stay in IDLE.
  - RUN: busy=1. Each cycle:
    - Drive the CLA with A=hi, B=mcand, sub=0.
    - Carry out c = (hi[15]&mcand[15]) | ((hi[15]^mcand[15]) & ~Sum[15]).
    - If lo[0]=1, then {c,Sum,lo} is shifted right 1 into {hi,lo}. Otherwise {0,hi,lo} is shifted right 1.
    - cnt<=cnt+1.
    - When cnt==ITERS-1, go to DONE.
  - DONE: on entry, prod<={hi,lo}. done=1 for exactly this cycle. Next state is IDLE.
- CLA Error output (signed overflow) is ignored. Unsigned carry comes only from the carry equation above.
- Latency:
  - start sampled high at edge k: RUN occupies edges k+1..k+16.
  - done is high and prod is valid in the cycle after edge k+16.
  - Next start is accepted at edge k+18 at earliest (back-to-back throughput of 18 cycles).
- Handshake rules:
  - start while busy or done is ignored; no queuing.
  - op_a and op_b are sampled only at the accepting edge. Later changes have no effect.
- abort:
  - In RUN: go to IDLE next edge. No done pulse, prod unchanged, hi/lo/cnt do not matter.
  - In IDLE: abort wins over start (no accept).
  - In DONE: no effect. The completion stands.
- rst:
  - Overrides start and abort in every state.
  - rst mid-RUN clears prod to 0 and suppresses done.
- Boundary conditions:
  - op_a=0 or op_b=0 gives prod=0 after the full 16 cycles. There is no early termination.
  - Maximum result 0xFFFF*0xFFFF=0xFFFE0001 must not lose the carry.
- cnt is 4 bits at WIDTH=16 ($clog2(ITERS)). It wraps only by leaving RUN, never while in it.

Decomposition:
- Package mul_seq_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t.
  - localparam MUL_WIDTH=16.
  - localparam MUL_ITERS=MUL_WIDTH.
- Sub-module: reuse the existing CLA_16bit unchanged, one instance, sub tied to 0.
- Carry derivation, datapath registers and FSM all live in mul_seq_16. No further sub-modules.

Test Plan:
- rst=1 for 2 cycles, then start=1 with op_a=3, op_b=5 -> busy high for 16 cycles, done pulses once in cycle 17, prod=0x0000000F held afterwards.
- op_a=0xFFFF, op_b=0xFFFF -> prod=0xFFFE0001. Then op_a=0x8000, op_b=0x0002 -> prod=0x00010000.
- Start 7*9; re-assert start with op_a=0x1234 on cycles 3..10 of RUN -> ignored, done once, prod=0x0000003F.
- Start 100*200; abort at RUN cycle 8 -> busy drops next edge, no done, prod keeps the previous value. New start afterwards completes normally.
- rst asserted at RUN cycle 5 -> next cycle busy=0, done=0, prod=0, state IDLE. start+abort together in IDLE -> not accepted.
- Random sweep of 512 operand pairs -> each prod equals the 32-bit unsigned reference product, exactly one done per start.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state type and sizing for the sequential multiplier.
package mul_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
   localparam int MUL_WIDTH = 16;
   localparam int MUL_ITERS = MUL_WIDTH;
endpackage

// File: rtl/mul_seq_16_if.sv
// mul_seq_16_if: multiplier request/result bundle.
//   start/abort/op_a/op_b : requester -> multiplier
//   busy/done/prod        : multiplier -> requester
interface mul_seq_16_if;
   import mul_seq_pkg::*;
   logic                     start;
   logic                     abort;
   logic [MUL_WIDTH-1:0]     op_a;
   logic [MUL_WIDTH-1:0]     op_b;
   logic                     busy;
   logic                     done;
   logic [2*MUL_WIDTH-1:0]   prod;
   modport master (output start, abort, op_a, op_b, input busy, done, prod);
   modport slave  (input start, abort, op_a, op_b, output busy, done, prod);
endinterface

// File: rtl/mul_seq_16_cla.sv
// CLA_16bit: 16-bit add/subtract, lookahead across 4-bit groups.
//   A, B  : operands
//   sub   : 1 = A - B, 0 = A + B
//   Sum   : result
//   Error : signed overflow
module CLA_16bit (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        sub,
   output logic [15:0] Sum,
   output logic        Error
);
   logic [15:0] bx, g, p;
   logic [3:0]  gg, gp;
   logic [4:0]  gc;
   logic [16:0] c;
   always_comb begin
      bx = B ^ {16{sub}};
      g  = A & bx;
      p  = A ^ bx;
      gc[0] = sub;
      for (int j = 0; j < 4; j++) begin
         gg[j] = g[4*j+3] | (p[4*j+3] & (g[4*j+2] | (p[4*j+2] & (g[4*j+1] | (p[4*j+1] & g[4*j])))));
         gp[j] = &p[4*j +: 4];
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
      c[0] = gc[0];
      for (int i = 1; i < 16; i++)
         c[i] = (i % 4 == 0) ? gc[i/4] : (g[i-1] | (p[i-1] & c[i-1]));
      c[16] = gc[4];
      Sum   = p ^ c[15:0];
      Error = c[16] ^ c[15];
   end
endmodule

// File: rtl/mul_seq_16.sv
// mul_seq_16: unsigned 16x16->32 shift-and-add multiplier reusing one CLA_16bit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/abort/op_a/op_b in, busy/done/prod out
module mul_seq_16
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int ITERS = WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   mul_seq_16_if.slave  bus
);
   localparam int CW = $clog2(ITERS);
   if (WIDTH != MUL_WIDTH) begin : g_width_check
      $error("mul_seq_16: WIDTH must match CLA_16bit width");
   end
   mul_state_t         state, state_n;
   logic [WIDTH-1:0]   hi, lo, mcand, sum;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH:0]   shifted;
   logic [CW-1:0]      cnt;
   logic               carry, last, cla_err_unused;
   CLA_16bit u_cla (.A(hi), .B(mcand), .sub(1'b0), .Sum(sum), .Error(cla_err_unused));
   always_comb begin
      // CLA has no carry-out port; rebuild unsigned carry from the top bits.
      carry   = (hi[WIDTH-1] & mcand[WIDTH-1]) | ((hi[WIDTH-1] ^ mcand[WIDTH-1]) & ~sum[WIDTH-1]);
      shifted = lo[0] ? {carry, sum, lo} : {1'b0, hi, lo};
      last    = cnt == CW'(ITERS - 1);
      state_n = state;
      case (state)
         IDLE:    state_n = (bus.start && !bus.abort) ? RUN : IDLE;
         RUN:     state_n = bus.abort ? IDLE : (last ? DONE : RUN);
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
         cnt   <= '0;
         prod  <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && state_n == RUN) begin
            lo    <= bus.op_a;
            mcand <= bus.op_b;
            hi    <= '0;
            cnt   <= '0;
         end
         if (state == RUN) begin
            {hi, lo} <= shifted[2*WIDTH:1];
            cnt      <= cnt + 1'b1;
         end
         if (state == RUN && state_n == DONE)
            prod <= shifted[2*WIDTH:1];
      end
   end
   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
   assign bus.prod = prod;
endmodule

// File: tb/tb_mul_seq_16.sv
// tb_mul_seq_16: directed and random checks of mul_seq_16 against a cycle-level behavioural model.
module tb_mul_seq_16;
   logic clk = 0;
   logic rst = 1;
   mul_seq_16_if bus ();
   mul_seq_16 dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int m_phase = 0, m_rem = 0, accepts = 0, dut_dones = 0;
   logic [31:0] m_prod = 0, m_pend = 0;
   bit armed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: idle (0) -> 16 running cycles (1) -> one done cycle (2) -> idle.
   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_rem   = 0;
         m_prod  = 0;
      end else begin
         case (m_phase)
            0: if (bus.start && !bus.abort) begin
                  m_pend  = {16'h0, bus.op_a} * {16'h0, bus.op_b};
                  m_rem   = 16;
                  m_phase = 1;
                  accepts++;
               end
            1: if (bus.abort) m_phase = 0;
               else begin
                  m_rem--;
                  if (m_rem == 0) begin
                     m_phase = 2;
                     m_prod  = m_pend;
                  end
               end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("busy", {31'h0, bus.busy}, {31'h0, m_phase == 1});
         chk("done", {31'h0, bus.done}, {31'h0, m_phase == 2});
         chk("prod", bus.prod, m_prod);
         if (bus.done) dut_dones++;
      end
   end

   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      bus.start = 1;
      bus.op_a  = a;
      bus.op_b  = b;
      @(negedge clk);
      bus.start = 0;
      bus.op_a  = 16'($urandom);
      bus.op_b  = 16'($urandom);
   endtask

   task automatic wait_done(output int nbusy);
      nbusy = 0;
      for (int i = 0; i < 40 && !bus.done; i++) begin
         if (bus.busy) nbusy++;
         @(negedge clk);
      end
      checks++;
      if (!bus.done) begin
         errors++;
         $display("FAIL done_timeout: got done=0 required done=1 at %0t", $time);
      end
   endtask

   task automatic mul(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp, input string name);
      int nb;
      start_op(a, b);
      wait_done(nb);
      chk({name, "_cycles"}, nb, 16);
      chk(name, bus.prod, exp);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nb, d0, n;
      logic [15:0] a, b;
      bus.start = 0;
      bus.abort = 0;
      bus.op_a  = 0;
      bus.op_b  = 0;
      @(posedge clk);
      armed = 1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_prod", bus.prod, 0);
      chk("rst_busy", {31'h0, bus.busy}, 0);
      rst = 0;

      start_op(16'd3, 16'd5);
      wait_done(nb);
      chk("t1_busy_cycles", nb, 16);
      chk("t1_prod", bus.prod, 32'h0000000F);
      chk("t1_model_pin", m_prod, 32'h0000000F);
      @(negedge clk);
      chk("t1_done_once", {31'h0, bus.done}, 0);
      chk("t1_hold", bus.prod, 32'h0000000F);

      mul(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "t2_max");
      mul(16'h8000, 16'h0002, 32'h00010000, "t2_carry");
      mul(16'h0000, 16'hFFFF, 32'h00000000, "t2_zero_a");
      mul(16'hFFFF, 16'h0000, 32'h00000000, "t2_zero_b");

      start_op(16'd7, 16'd9);
      d0 = dut_dones;
      n  = 1;
      for (int i = 0; i < 40 && !bus.done; i++) begin
         bus.start = n >= 3 && n <= 10;
         bus.op_a  = 16'h1234;
         @(negedge clk);
         n++;
      end
      bus.start = 0;
      chk("t3_done_seen", {31'h0, bus.done}, 1);
      chk("t3_prod", bus.prod, 32'h0000003F);
      repeat (3) @(negedge clk);
      chk("t3_one_done", dut_dones - d0, 1);

      start_op(16'd100, 16'd200);
      d0 = dut_dones;
      repeat (7) @(negedge clk);
      bus.abort = 1;
      @(negedge clk);
      bus.abort = 0;
      chk("t4_busy_drop", {31'h0, bus.busy}, 0);
      repeat (20) @(negedge clk);
      chk("t4_no_done", dut_dones - d0, 0);
      chk("t4_prod_kept", bus.prod, 32'h0000003F);
      mul(16'd6, 16'd7, 32'd42, "t4_after");

      start_op(16'd1234, 16'd5678);
      d0 = dut_dones;
      repeat (4) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("t5_busy", {31'h0, bus.busy}, 0);
      chk("t5_done", {31'h0, bus.done}, 0);
      chk("t5_prod", bus.prod, 0);
      rst = 0;
      bus.start = 1;
      bus.abort = 1;
      bus.op_a  = 16'd9;
      bus.op_b  = 16'd9;
      @(negedge clk);
      bus.start = 0;
      bus.abort = 0;
      chk("t5_no_accept", {31'h0, bus.busy}, 0);
      repeat (20) @(negedge clk);
      chk("t5_no_done", dut_dones - d0, 0);

      for (int i = 0; i < 512; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         mul(a, b, 32'(a) * 32'(b), "t6_rand");
      end

      chk("done_per_start", dut_dones, accepts - 2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
